// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: responder for the multiplexed address/data RTC bus.
// Decodes address-latch, data-write and data-read cycles against an internal
// register file and drives the bidirectional data bus during reads.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   a_d            0 = address phase, 1 = data phase
//   cs, wr, rd     active-low chip select / write strobe / read strobe
//   dato           multiplexed address/data bus (driven only in RD_ACT)
//   reg_address    last latched address (debug)
//   flag_escritura one-cycle pulse when a data write commits
//
// Optional feature macro: RTC_TIMEKEEP_EN
//   When defined, mem[0..2] hold BCD seconds/minutes/hours advanced by a
//   1 Hz tick derived from CLK_HZ. Requires DEPTH >= 3.
module rtc_bus_responder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    inout  wire  [7:0] dato,
    output logic [7:0] reg_address,
    output logic       flag_escritura
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject configurations the address decode or timekeeper cannot support.
`ifdef RTC_TIMEKEEP_EN
    if (DEPTH < 3 || DEPTH > 256 || CLK_HZ < 1) begin : g_bad_cfg
        $error("rtc_bus_responder: DEPTH must be 3..256 and CLK_HZ >= 1");
    end
`else
    if (DEPTH < 1 || DEPTH > 256 || CLK_HZ < 1) begin : g_bad_cfg
        $error("rtc_bus_responder: DEPTH must be 1..256 and CLK_HZ >= 1");
    end
`endif

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

    logic [1:0] a_d_sync, cs_sync;
    logic [2:0] wr_sync, rd_sync;      // [2] is the edge-reference stage
    logic [7:0] dato_m, dato_s;

    state_t     state_q, state_d;
    logic       oe_q, oe_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] addr_d;
    logic       mem_we;
    logic [7:0] mem [DEPTH];

    logic a_d_s, cs_s, wr_s, rd_s;
    logic wr_fall, wr_rise, rd_fall;
    logic addr_ok;
    logic [7:0] mem_rdata;

    // Input synchronizers; reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_d_sync <= 2'b11;
            cs_sync  <= 2'b11;
            wr_sync  <= 3'b111;
            rd_sync  <= 3'b111;
            dato_m   <= 8'hFF;
            dato_s   <= 8'hFF;
        end else begin
            a_d_sync <= {a_d_sync[0], a_d};
            cs_sync  <= {cs_sync[0], cs};
            wr_sync  <= {wr_sync[1:0], wr};
            rd_sync  <= {rd_sync[1:0], rd};
            dato_m   <= dato;
            dato_s   <= dato_m;
        end
    end

    assign a_d_s   = a_d_sync[1];
    assign cs_s    = cs_sync[1];
    assign wr_s    = wr_sync[1];
    assign rd_s    = rd_sync[1];
    assign wr_fall = wr_sync[2] & ~wr_s;
    assign wr_rise = ~wr_sync[2] & wr_s;
    assign rd_fall = rd_sync[2] & ~rd_s;

    assign addr_ok   = (32'(reg_address) < DEPTH);
    assign mem_rdata = addr_ok ? mem[reg_address[AW-1:0]] : 8'h00;

    // Bus cycle decode; a wr edge is examined before rd so writes win.
    always_comb begin
        state_d   = state_q;
        oe_d      = 1'b0;
        rd_data_d = rd_data_q;
        addr_d    = reg_address;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_fall && !cs_s) begin
                    state_d = WR_ACT;
                end else if (rd_fall && !cs_s && a_d_s) begin
                    state_d   = RD_ACT;
                    oe_d      = 1'b1;
                    rd_data_d = mem_rdata;
                end
            end
            WR_ACT: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else if (wr_rise) begin
                    state_d = IDLE;
                    if (!a_d_s) begin
                        addr_d = dato_s;
                    end else if (addr_ok) begin
                        mem_we = 1'b1;
                    end
                end
            end
            RD_ACT: begin
                if (rd_s || cs_s) begin
                    state_d = IDLE;
                end else begin
                    oe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            oe_q           <= 1'b0;
            rd_data_q      <= 8'h00;
            reg_address    <= 8'h00;
            flag_escritura <= 1'b0;
        end else begin
            state_q        <= state_d;
            oe_q           <= oe_d;
            rd_data_q      <= rd_data_d;
            reg_address    <= addr_d;
            flag_escritura <= mem_we;
        end
    end

    assign dato = oe_q ? rd_data_q : 8'hzz;

`ifdef RTC_TIMEKEEP_EN
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc_q;
    logic          tick, sec_wr, sec_cy, min_cy;
    logic [7:0]    sec_nx, min_nx, hr_nx;

    // BCD +1 without wrap; the caller handles the rollover value.
    function automatic logic [7:0] bcd_step(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick   = (presc_q == PW'(CLK_HZ - 1));
    assign sec_wr = mem_we && (reg_address == 8'd0);
    assign sec_cy = (mem[0] == 8'h59);
    assign min_cy = (mem[1] == 8'h59);
    assign sec_nx = sec_cy ? 8'h00 : bcd_step(mem[0]);
    assign min_nx = min_cy ? 8'h00 : bcd_step(mem[1]);
    assign hr_nx  = (mem[2] == 8'h23) ? 8'h00 : bcd_step(mem[2]);

    // 1 Hz prescaler; a seconds write restarts the second.
    always_ff @(posedge clk) begin
        if (reset || sec_wr || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end
`endif

    // Register file; a bus write lands after any tick update so it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: 8'h00};
        end else begin
`ifdef RTC_TIMEKEEP_EN
            if (tick) begin
                mem[0] <= sec_nx;
                if (sec_cy) begin
                    mem[1] <= min_nx;
                    if (min_cy) begin
                        mem[2] <= hr_nx;
                    end
                end
            end
`endif
            if (mem_we) begin
                mem[reg_address[AW-1:0]] <= dato_s;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: directed table, hand-written
// corner sequences, then random bus cycles against a register-file model.
module tb_rtc_bus_responder;

    localparam int unsigned DEPTH = 16;
    localparam int K_ADDR = 0, K_DATA = 1, K_READ = 2, K_READ_AD0 = 3, K_WR_NOCS = 4;

    typedef struct {
        int         kind;
        logic [7:0] val;
        logic [7:0] exp;       // flag for writes, bus data for reads
        logic [7:0] exp_addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, a_d, cs, wr, rd, tb_drive;
    logic [7:0] tb_dato;
    wire  [7:0] dato;
    logic [7:0] reg_address;
    logic       flag_escritura;

    int errors = 0;
    int checks = 0;
    int flag_cnt = 0;

    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_addr;
    vec_t       vecs [18];

    assign dato = tb_drive ? tb_dato : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (dato[i]);
    end

    rtc_bus_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .wr(wr), .rd(rd),
        .dato(dato), .reg_address(reg_address), .flag_escritura(flag_escritura)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (flag_escritura) flag_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic ad, input logic [7:0] v);
        cs = 1'b0; a_d = ad; tb_dato = v; tb_drive = 1'b1;
        tick(2); wr = 1'b0;
        tick(6); wr = 1'b1;
        tick(4); cs = 1'b1; tb_drive = 1'b0; a_d = 1'b0;
        tick(4);
    endtask

    // Undriven bus reads 8'hFF through the pullups; test data never uses FF.
    task automatic bus_read(input logic ad, input logic [7:0] exp, input string nm);
        cs = 1'b0; a_d = ad; tb_drive = 1'b0;
        tick(2); rd = 1'b0;
        tick(2); check8({nm, "_pre"}, dato, 8'hFF);
        tick(1); check8({nm, "_drv"}, dato, exp);
        tick(3); check8({nm, "_hold"}, dato, exp);
        rd = 1'b1;
        tick(3); check8({nm, "_rel"}, dato, 8'hFF);
        cs = 1'b1; a_d = 1'b0;
        tick(3);
    endtask

    task automatic do_op(input int k, input logic [7:0] v, input logic [7:0] exp,
                         input logic [7:0] exp_addr, input string nm);
        int f0;
        logic [7:0] exp_flag;
        f0 = flag_cnt;
        exp_flag = 8'h00;
        case (k)
            K_ADDR:     bus_write(1'b0, v);
            K_DATA:     begin bus_write(1'b1, v); exp_flag = exp; end
            K_READ:     bus_read(1'b1, exp, nm);
            K_READ_AD0: bus_read(1'b0, 8'hFF, nm);
            default: begin
                cs = 1'b1; a_d = 1'b0; tb_dato = v; tb_drive = 1'b1;
                tick(2); wr = 1'b0;
                tick(6); wr = 1'b1;
                tick(4); tb_drive = 1'b0;
                tick(2);
            end
        endcase
        check8({nm, "_flag"}, 8'(flag_cnt - f0), exp_flag);
        check8({nm, "_addr"}, reg_address, exp_addr);
    endtask

    task automatic do_reset();
        reset = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b1; a_d = 1'b0; tb_drive = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'h00;
        m_addr = 8'h00;
    endtask

    initial begin
        int f0;
        tb_dato = 8'h00;
        do_reset();
        check8("rst_addr", reg_address, 8'h00);
        check8("rst_flag", 8'(flag_escritura), 8'h00);
        check8("rst_bus", dato, 8'hFF);

        vecs[0]  = '{K_ADDR,     8'h05, 8'h00, 8'h05};
        vecs[1]  = '{K_DATA,     8'hA7, 8'h01, 8'h05};
        vecs[2]  = '{K_READ,     8'h00, 8'hA7, 8'h05};
        vecs[3]  = '{K_READ_AD0, 8'h00, 8'hFF, 8'h05};
        vecs[4]  = '{K_ADDR,     8'h20, 8'h00, 8'h20};
        vecs[5]  = '{K_DATA,     8'h55, 8'h00, 8'h20};
        vecs[6]  = '{K_READ,     8'h00, 8'h00, 8'h20};
        vecs[7]  = '{K_ADDR,     8'h05, 8'h00, 8'h05};
        vecs[8]  = '{K_READ,     8'h00, 8'hA7, 8'h05};
        vecs[9]  = '{K_WR_NOCS,  8'h0A, 8'h00, 8'h05};
        vecs[10] = '{K_ADDR,     8'h0F, 8'h00, 8'h0F};
        vecs[11] = '{K_DATA,     8'h3E, 8'h01, 8'h0F};
        vecs[12] = '{K_READ,     8'h00, 8'h3E, 8'h0F};
        vecs[13] = '{K_ADDR,     8'h10, 8'h00, 8'h10};
        vecs[14] = '{K_DATA,     8'h99, 8'h00, 8'h10};
        vecs[15] = '{K_READ,     8'h00, 8'h00, 8'h10};
        vecs[16] = '{K_ADDR,     8'h00, 8'h00, 8'h00};
        vecs[17] = '{K_READ,     8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 18; i++)
            do_op(vecs[i].kind, vecs[i].val, vecs[i].exp, vecs[i].exp_addr,
                  $sformatf("vec%0d", i));

        // wr and rd low together: write commits, bus never driven.
        do_op(K_ADDR, 8'h02, 8'h00, 8'h02, "both_addr");
        f0 = flag_cnt;
        cs = 1'b0; a_d = 1'b1; tb_dato = 8'h11; tb_drive = 1'b1;
        tick(2); wr = 1'b0; rd = 1'b0;
        tick(6); wr = 1'b1;
        tick(4); tb_drive = 1'b0;
        tick(1); check8("both_bus0", dato, 8'hFF);
        tick(3); check8("both_bus1", dato, 8'hFF);
        rd = 1'b1;
        tick(3); cs = 1'b1; a_d = 1'b0;
        tick(3);
        check8("both_flag", 8'(flag_cnt - f0), 8'h01);
        do_op(K_READ, 8'h00, 8'h11, 8'h02, "both_rd");

        // cs rising inside a write aborts it.
        do_op(K_ADDR, 8'h04, 8'h00, 8'h04, "abort_addr");
        do_op(K_DATA, 8'h9A, 8'h01, 8'h04, "abort_pre");
        f0 = flag_cnt;
        cs = 1'b0; a_d = 1'b1; tb_dato = 8'h77; tb_drive = 1'b1;
        tick(2); wr = 1'b0;
        tick(6); cs = 1'b1;
        tick(4); wr = 1'b1;
        tick(4); tb_drive = 1'b0; a_d = 1'b0;
        tick(3);
        check8("abort_flag", 8'(flag_cnt - f0), 8'h00);
        do_op(K_READ, 8'h00, 8'h9A, 8'h04, "abort_rd");

        // Reset during an active read releases the bus at once.
        do_op(K_ADDR, 8'h03, 8'h00, 8'h03, "rrst_addr");
        do_op(K_DATA, 8'h5A, 8'h01, 8'h03, "rrst_data");
        cs = 1'b0; a_d = 1'b1;
        tick(2); rd = 1'b0;
        tick(4); check8("rrst_drv", dato, 8'h5A);
        reset = 1'b1;
        tick(1); check8("rrst_rel", dato, 8'hFF);
        rd = 1'b1; cs = 1'b1; a_d = 1'b0;
        tick(2); reset = 1'b0;
        tick(3);

        // Reset during a data write discards it.
        do_op(K_ADDR, 8'h03, 8'h00, 8'h03, "wrst_addr");
        f0 = flag_cnt;
        cs = 1'b0; a_d = 1'b1; tb_dato = 8'h3C; tb_drive = 1'b1;
        tick(2); wr = 1'b0;
        tick(4); reset = 1'b1;
        tick(1); wr = 1'b1; tb_drive = 1'b0;
        tick(1); check8("wrst_bus", dato, 8'hFF);
        tick(1); cs = 1'b1; a_d = 1'b0; reset = 1'b0;
        tick(4);
        check8("wrst_flag", 8'(flag_cnt - f0), 8'h00);
        check8("wrst_addr0", reg_address, 8'h00);
        do_op(K_ADDR, 8'h03, 8'h00, 8'h03, "wrst_addr2");
        do_op(K_READ, 8'h00, 8'h00, 8'h03, "wrst_rd");

        // Random cycles against the register-file model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int k;
            logic [7:0] v, e;
            k = int'($urandom_range(0, 2));
            e = 8'h00;
            if (k == K_ADDR) begin
                v = 8'($urandom_range(0, 19));
                m_addr = v;
            end else if (k == K_DATA) begin
                v = 8'($urandom_range(0, 254));
                if (32'(m_addr) < DEPTH) begin
                    m_mem[m_addr[3:0]] = v;
                    e = 8'h01;
                end
            end else begin
                v = 8'h00;
                e = (32'(m_addr) < DEPTH) ? m_mem[m_addr[3:0]] : 8'h00;
            end
            do_op(k, v, e, m_addr, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
